// File: rtl/alu_exec.sv
// alu_exec: single-issue 32-bit ALU with a valid/ready handshake on both sides.
// Most operations finish on the accept edge. SLL/SRL are serial: one bit per
// cycle, so a shift by N takes N cycles. Results stay held until consumed.
module alu_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  ALU_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_ADDR  = 4'b1000;
  localparam logic [3:0] OP_BCMP  = 4'b1001;
  localparam logic [3:0] OP_SLT   = 4'b1100;
  localparam logic [3:0] OP_SLTU  = 4'b1101;

  state_t      state;
  logic [31:0] work;        // shift working register, separate from result
  logic [4:0]  cnt;         // remaining single-bit shift steps
  logic        shift_left;  // direction of the shift in flight

  logic [31:0] op_result;
  logic        op_illegal;
  logic        op_is_shift;
  logic [4:0]  shamt;
  logic [31:0] work_next;

  assign shamt = b[4:0];

  // Single-cycle datapath evaluated on the operands presented at accept time
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_result   = '0;
    op_illegal  = 1'b0;
    op_is_shift = 1'b0;
    case (ALU_control)
      OP_ADD, OP_ADDR: op_result = a + b;
      OP_SUB, OP_BCMP: op_result = a - b;
      OP_AND:          op_result = a & b;
      OP_OR:           op_result = a | b;
      OP_XOR:          op_result = a ^ b;
      OP_SLL, OP_SRL: begin
        // A zero shift amount completes immediately with the operand unchanged
        op_result   = a;
        op_is_shift = (shamt != 5'd0);
      end
      OP_SLT:          op_result = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:         op_result = {31'd0, a < b};
      default:         op_illegal = 1'b1;
    endcase
  end

  // One-bit step of the serial shifter
  always_comb begin
    work_next = shift_left ? {work[30:0], 1'b0} : {1'b0, work[31:1]};
  end

  // Control FSM with registered handshake flags and result registers
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift working register is reset too; it is a handful of flops, not a memory, and a clean value keeps simulation X-free.
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      illegal    <= 1'b0;
      work       <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (op_is_shift) begin
              work       <= a;
              cnt        <= shamt;
              shift_left <= (ALU_control == OP_SLL);
              state      <= SHIFT;
            end else begin
              result    <= op_result;
              zero      <= (op_result == '0);
              illegal   <= op_illegal;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result    <= work_next;
            zero      <= (work_next == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here means no new accept on the handshake edge
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors for alu_exec. The driver pushes the expected
// response into a scoreboard queue on each accept; an independent monitor
// pops it when out_valid rises and keeps checking while the result is held.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALU_control;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_exec dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALU_control (ALU_control),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          acc;    // cycle count just after the accept edge
    int          delay;  // edges after accept until out_valid is high
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per result and checks it stays stable until consumed
  exp_t cur;
  bit   have_cur = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          check("latency", cyc, cur.acc + cur.delay);
          check("result", result, cur.res);
          check("zero", {31'd0, zero}, {31'd0, cur.z});
          check("illegal", {31'd0, illegal}, {31'd0, cur.ill});
        end
      end else begin
        check("hold_result", result, cur.res);
        check("hold_zero", {31'd0, zero}, {31'd0, cur.z});
        check("hold_illegal", {31'd0, illegal}, {31'd0, cur.ill});
      end
      if (out_ready) have_cur = 1'b0;
    end
  end

  // Issue one operation; returns #1 after the accept edge with inputs scrambled
  task automatic do_op(input logic [3:0] ctl, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic ez, input logic ei,
                       input int dly, input bit push);
    exp_t e;
    int   waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    ALU_control = ctl;
    a           = av;
    b           = bv;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    if (push) begin
      e.res = er; e.z = ez; e.ill = ei; e.acc = cyc; e.delay = dly;
      sb.push_back(e);
    end
    in_valid    = 1'b0;
    ALU_control = 4'($urandom_range(0, 15));
    a           = $urandom;
    b           = $urandom;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((sb.size() != 0 || have_cur || !in_ready) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int lows;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    ALU_control = 4'd0;
    a           = '0;
    b           = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // First cycle after reset deasserts
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);

    // Single-cycle operations
    do_op(4'b0000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0, 0, 1'b1);
    do_op(4'b1001, 32'h1234,      32'h1234,      32'h0,         1'b1, 1'b0, 0, 1'b1);
    do_op(4'b1100, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 0, 1'b1);
    do_op(4'b1101, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 0, 1'b1);
    do_op(4'b1100, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 0, 1'b1);
    do_op(4'b1101, 32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 0, 1'b1);
    do_op(4'b0010, 32'hF0F0_FFFF, 32'h0FF0_F00F, 32'h00F0_F00F, 1'b0, 1'b0, 0, 1'b1);
    do_op(4'b0011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 0, 1'b1);
    do_op(4'b0100, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0, 0, 1'b1);
    do_op(4'b1000, 32'hFFFF_FFFF, 32'h2,         32'h1,         1'b0, 1'b0, 0, 1'b1);
    do_op(4'b0001, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b1);
    do_op(4'b0101, 32'hDEAD_BEEF, 32'h20,        32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b1);
    wait_drain();

    // Serial shifts: SLL by 31 keeps in_ready low throughout
    do_op(4'b0101, 32'h1, 32'h1F, 32'h8000_0000, 1'b0, 1'b0, 31, 1'b1);
    lows = 0;
    for (int i = 0; i < 31; i++) begin
      if (!in_ready) lows++;
      @(posedge clk); #1;
    end
    check("sll31_in_ready_low", lows, 31);
    do_op(4'b0110, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1'b0, 4, 1'b1);
    do_op(4'b0110, 32'hFFFF_FFFF, 32'h1,  32'h7FFF_FFFF, 1'b0, 1'b0, 1, 1'b1);
    do_op(4'b0101, 32'h8000_0000, 32'h1,  32'h0,         1'b1, 1'b0, 1, 1'b1);

    // Illegal codes, then a legal op clears the flag
    do_op(4'b0111, 32'h5, 32'h5, 32'h0, 1'b1, 1'b1, 0, 1'b1);
    do_op(4'b0000, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 0, 1'b1);
    do_op(4'b1111, 32'h9, 32'h3, 32'h0, 1'b1, 1'b1, 0, 1'b1);
    wait_drain();

    // Backpressure: result held while out_ready is low, new requests ignored
    out_ready = 1'b0;
    do_op(4'b0000, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0, 0, 1'b1);
    ALU_control = 4'b0001;
    a           = 32'h10;
    b           = 32'h1;
    in_valid    = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    // Handshake edge returns to IDLE without accepting the pending request
    check("bp_back_to_idle", {31'd0, in_ready}, 32'd1);
    check("bp_out_valid_low", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    wait_drain();

    // Reset during the 3rd SHIFT cycle of a 20-bit shift, with a request pending
    do_op(4'b0101, 32'h3, 32'h14, 32'h0, 1'b0, 1'b0, 20, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset       = 1'b1;
    in_valid    = 1'b1;
    ALU_control = 4'b0000;
    a           = 32'h1;
    b           = 32'h1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd0);
    check("midrst_illegal", {31'd0, illegal}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    // Any out_valid from the discarded shift is flagged by the monitor
    repeat (25) @(posedge clk);
    #1 check("midrst_no_stale", {31'd0, out_valid}, 32'd0);

    // The block is usable again after the abort
    do_op(4'b0100, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b0, 1'b0, 0, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
